sram_extension: RTL and testbench
=================================

SRAM_EXTENSION -- requirements
Module: sram_extension

Interface
REQ-001 Parameter BW_DATA, default 64, word width of the extended memory; SHALL be a positive multiple of BW_BANK.
REQ-002 Parameter BW_ADDR, default 6, address width; depth SHALL be 2**BW_ADDR words (64).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  asynchronous, active-low reset.
REQ-005 i_data  input  BW_DATA  write data.
REQ-006 i_addr  input  BW_ADDR  word address for read and write.
REQ-007 i_wen  input  1  write enable, active high (1 = write, 0 = read).
REQ-008 i_cen  input  1  chip enable, active high; no access when 0.
REQ-009 i_oen  input  1  output enable, active high.
REQ-010 o_data  output  BW_DATA  read data.

Function
REQ-011 Write: when i_cen=1 and i_wen=1 at a rising edge, mem[i_addr] SHALL take i_data, all BW_DATA bits, same edge.
REQ-012 Read: when i_cen=1 and i_wen=0 at a rising edge, the internal read register SHALL take mem[i_addr]; 1-cycle latency.
REQ-013 When i_cen=0, memory and read register SHALL hold; i_wen and i_addr ignored.
REQ-014 o_data SHALL equal the read register when i_oen=1, else all zeros (no tri-state); i_oen is combinational, no added latency.
REQ-015 Write cycles SHALL NOT update the read register (except per REQ-021); o_data keeps last read value.
REQ-016 Read of a never-written address SHALL return the memory's uninitialised value (X in simulation); no defined content required.
REQ-017 Read and write of the same address on consecutive edges: the read SHALL return the data written on the previous edge.
REQ-018 Address wraps naturally; no out-of-range addresses exist.

Reset
REQ-019 i_rstn=0 SHALL asynchronously clear the read register to 0, so o_data=0 regardless of i_oen.
REQ-020 Reset SHALL NOT clear memory contents; access while i_rstn=0 SHALL be ignored; operation resumes at first rising edge after deassertion.

Configuration
REQ-021 Macro SRAM_EXT_WR_THROUGH_EN defined: a write cycle (i_cen=1, i_wen=1) SHALL also load i_data into the read register, so o_data shows written data the next cycle when i_oen=1. Undefined: REQ-015 applies unchanged.

Structure
REQ-022 Shared package sram_ext_pkg SHALL hold BW_BANK=32 (bank macro width) and the derived constant NUM_BANK=BW_DATA/BW_BANK.
REQ-023 Sub-module sram_bank (BW_BANK wide, 2**BW_ADDR deep, same cen/wen/addr/clk, synchronous read) SHALL be instantiated NUM_BANK times side by side; bank k holds bits [k*BW_BANK +: BW_BANK]. All banks share address and control.
REQ-024 The read register, output gating and reset logic SHALL live in sram_extension, not in sram_bank.

Verification
REQ-025 Reset: i_rstn=0 with i_oen=1 -> o_data=0 immediately, without a clock edge.
REQ-026 Fill/readback: write addr i with 64'h0000_0000_xxxx_xxxx random, i=0..63, then read 0..63 with i_oen=1 -> o_data equals written word one cycle after each read edge.
REQ-027 Full-width: write 64'hDEAD_BEEF_CAFE_F00D to addr 6'h3F, read -> 64'hDEAD_BEEF_CAFE_F00D (both banks correct).
REQ-028 Output gating: after reading 64'h1234 at addr 5, drop i_oen -> o_data=0; raise i_oen -> 64'h1234 with no clock edge.
REQ-029 Chip disable: i_cen=0, i_wen=1, i_data=64'hFFFF to addr 5 -> subsequent read of addr 5 still 64'h1234.
REQ-030 Write-through (macro defined): write 64'hA5A5 to addr 7 with i_oen=1 -> o_data=64'hA5A5 next cycle; macro undefined -> o_data unchanged.

Source files
------------

// File: rtl/sram_ext_pkg.sv
// Shared constants for the banked SRAM extension.
// Bank macro width and bank-count helper.
package sram_ext_pkg;

  localparam int BW_BANK = 32;
  localparam int BW_DATA_DEF = 64;
  localparam int NUM_BANK = BW_DATA_DEF / BW_BANK;

  function automatic int num_bank(input int bw_data);
    return bw_data / BW_BANK;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One bank macro: BW_BANK wide, 2**BW_ADDR deep.
// Synchronous write; read word is sampled by the caller's register.
module sram_bank
  import sram_ext_pkg::*;
#(
  parameter int BW_ADDR = 6
) (
  input  logic               clk,
  input  logic               cen,
  input  logic               wen,
  input  logic [BW_ADDR-1:0] addr,
  input  logic [BW_BANK-1:0] wdata,
  output logic [BW_BANK-1:0] rdata
);

  localparam int DEPTH = 2 ** BW_ADDR;

  logic [BW_BANK-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cen && wen) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sram_extension.sv
// Wide SRAM built from BW_BANK-wide banks with a shared read register.
// Optional SRAM_EXT_WR_THROUGH_EN: writes also load the read register.
module sram_extension
  import sram_ext_pkg::*;
#(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_data,
  input  logic [BW_ADDR-1:0] i_addr,
  input  logic               i_wen,
  input  logic               i_cen,
  input  logic               i_oen,
  output logic [BW_DATA-1:0] o_data
);

  localparam int NB = num_bank(BW_DATA);

  logic               acc;
  logic [BW_DATA-1:0] rd_word;
  logic [BW_DATA-1:0] rd_q;

  // Accesses during reset are dropped, memory is kept.
  assign acc = i_cen & i_rstn;

  for (genvar k = 0; k < NB; k++) begin : g_bank
    sram_bank #(
      .BW_ADDR(BW_ADDR)
    ) u_bank (
      .clk  (i_clk),
      .cen  (acc),
      .wen  (i_wen),
      .addr (i_addr),
      .wdata(i_data[k*BW_BANK +: BW_BANK]),
      .rdata(rd_word[k*BW_BANK +: BW_BANK])
    );
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_q <= '0;
    end else if (i_cen) begin
      if (!i_wen) begin
        rd_q <= rd_word;
      end
`ifdef SRAM_EXT_WR_THROUGH_EN
      else begin
        rd_q <= i_data;
      end
`endif
    end
  end

  assign o_data = i_oen ? rd_q : '0;

endmodule

// File: tb/tb_sram_extension.sv
// Self-checking bench for sram_extension.
// Reference model: plain word array plus last-read value.
module tb_sram_extension;

`ifdef SRAM_EXT_WR_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [63:0] din;
  logic [5:0]  addr;
  logic        wen;
  logic        cen;
  logic        oen;
  logic [63:0] dout;

  logic [63:0] model [64];
  logic [63:0] rd_model;
  int checks;
  int errors;

  sram_extension dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_data(din),
    .i_addr(addr),
    .i_wen (wen),
    .i_cen (cen),
    .i_oen (oen),
    .o_data(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [63:0] d);
    cen = 1'b1; wen = 1'b1; addr = a; din = d;
    cyc();
    model[a] = d;
    if (WT) rd_model = d;
    cen = 1'b0; wen = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a);
    cen = 1'b1; wen = 1'b0; addr = a;
    cyc();
    rd_model = model[a];
    cen = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; oen = 1'b1; cen = 1'b0; wen = 1'b0;
    addr = '0; din = '0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (dout !== 64'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", dout, 64'h0);
    end
    cyc();
    checks++;
    if (dout !== 64'h0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", dout, 64'h0);
    end
    rstn = 1'b1;
    rd_model = '0;
  endtask

  task automatic test_fill();
    oen = 1'b1;
    for (int i = 0; i < 64; i++) begin
      do_write(6'(i), {32'h0, 32'($urandom)});
    end
    for (int i = 0; i < 64; i++) begin
      do_read(6'(i));
      checks++;
      if (dout !== rd_model) begin
        errors++;
        $display("FAIL fill_read a=%0d got=%h exp=%h", i, dout, rd_model);
      end
    end
  endtask

  task automatic test_full_width();
    do_write(6'h3F, 64'hDEAD_BEEF_CAFE_F00D);
    do_read(6'h3F);
    checks++;
    if (dout !== 64'hDEAD_BEEF_CAFE_F00D) begin
      errors++;
      $display("FAIL full_width got=%h exp=%h", dout, 64'hDEAD_BEEF_CAFE_F00D);
    end
  endtask

  task automatic test_gating();
    do_write(6'd5, 64'h1234);
    do_read(6'd5);
    checks++;
    if (dout !== 64'h1234) begin
      errors++;
      $display("FAIL gate_read got=%h exp=%h", dout, 64'h1234);
    end
    oen = 1'b0;
    #1;
    checks++;
    if (dout !== 64'h0) begin
      errors++;
      $display("FAIL gate_off got=%h exp=%h", dout, 64'h0);
    end
    oen = 1'b1;
    #1;
    checks++;
    if (dout !== 64'h1234) begin
      errors++;
      $display("FAIL gate_on got=%h exp=%h", dout, 64'h1234);
    end
  endtask

  task automatic test_chip_disable();
    cen = 1'b0; wen = 1'b1; addr = 6'd5; din = 64'hFFFF;
    cyc();
    wen = 1'b0;
    checks++;
    if (dout !== 64'h1234) begin
      errors++;
      $display("FAIL cen_hold got=%h exp=%h", dout, 64'h1234);
    end
    do_read(6'd5);
    checks++;
    if (dout !== 64'h1234) begin
      errors++;
      $display("FAIL cen_mem got=%h exp=%h", dout, 64'h1234);
    end
  endtask

  task automatic test_write_through();
    logic [63:0] exp;
    oen = 1'b1;
    exp = WT ? 64'hA5A5 : 64'h1234;
    do_write(6'd7, 64'hA5A5);
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL wr_through got=%h exp=%h", dout, exp);
    end
    do_read(6'd7);
    checks++;
    if (dout !== 64'hA5A5) begin
      errors++;
      $display("FAIL wr_then_rd got=%h exp=%h", dout, 64'hA5A5);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic [5:0]  a;
    for (int i = 0; i < 8; i++) begin
      a = 6'($urandom);
      d = {32'($urandom), 32'($urandom)};
      do_write(a, d);
      do_read(a);
      checks++;
      if (dout !== d) begin
        errors++;
        $display("FAIL b2b a=%0d got=%h exp=%h", a, dout, d);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] exp;
    for (int i = 0; i < 300; i++) begin
      cen  = 1'($urandom);
      wen  = 1'($urandom);
      addr = 6'($urandom);
      din  = {32'($urandom), 32'($urandom)};
      oen  = ($urandom_range(0, 3) != 0);
      cyc();
      if (cen) begin
        if (!wen) rd_model = model[addr];
        else if (WT) rd_model = din;
        if (wen) model[addr] = din;
      end
      exp = oen ? rd_model : 64'h0;
      checks++;
      if (dout !== exp) begin
        errors++;
        $display("FAIL random i=%0d got=%h exp=%h", i, dout, exp);
      end
    end
    cen = 1'b0; wen = 1'b0; oen = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] keep;
    keep = model[9];
    do_read(6'd9);
    rstn = 1'b0;
    #1;
    checks++;
    if (dout !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid got=%h exp=%h", dout, 64'h0);
    end
    cen = 1'b1; wen = 1'b1; addr = 6'd9; din = ~keep;
    cyc();
    cen = 1'b1; wen = 1'b0;
    cyc();
    cen = 1'b0;
    checks++;
    if (dout !== 64'h0) begin
      errors++;
      $display("FAIL rst_ignore got=%h exp=%h", dout, 64'h0);
    end
    rstn = 1'b1;
    rd_model = '0;
    do_read(6'd9);
    checks++;
    if (dout !== keep) begin
      errors++;
      $display("FAIL rst_keep_mem got=%h exp=%h", dout, keep);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_full_width();
    test_gating();
    test_chip_disable();
    test_write_through();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
